mult_share_arbiter: RTL and testbench

- Shares one sequential W x W multiplier (valid/done handshake) among N_REQ requesters.
- Round-robin arbitration; latches the winner's operands and issues one multiply.
- Waits for done, then returns the 2W-bit product to the winner with a one-cycle response strobe.
- Sits between client FSMs and the single multiplier instance; one operation in flight at a time.

---
 rtl/mult_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential W x W multiplier among N_REQ requesters.
// Optional WAIT-state timeout is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*W-1:0] i_a,
    input  logic [N_REQ*W-1:0] i_b,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_rsp_valid,
    output logic [2*W-1:0]     o_rsp_data,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_m_valid,
    output logic [W-1:0]       o_m_a,
    output logic [W-1:0]       o_m_b,
    input  logic [2*W-1:0]     i_m_mult,
    input  logic               i_m_done
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [2*W-1:0]   r_rsp_data;
    logic             r_busy;
    logic             r_m_valid;
    logic [W-1:0]     r_m_a;
    logic [W-1:0]     r_m_b;

    logic             w_found;
    logic [IW-1:0]    w_winner;
    logic [IW:0]      w_sum;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    r_cnt;
    logic             r_err;
`else
    logic             w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // First set request searching upward from r_ptr with wrap-around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N_REQ)) begin
                w_sum = w_sum - (IW+1)'(N_REQ);
            end
            if (!w_found && i_req[w_sum[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == IW'(i)) begin
                w_a = i_a[i*W +: W];
                w_b = i_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_a       <= '0;
            r_m_b       <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_winner;
                        r_m_a     <= w_a;
                        r_m_b     <= w_b;
                        r_gnt     <= N_REQ'(1) << w_winner;
                        r_m_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_gnt     <= '0;
                    r_m_valid <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (i_m_done) begin
                        r_rsp_data  <= i_m_mult;
                        r_rsp_valid <= N_REQ'(1) << r_owner;
                        r_state     <= RESP;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    // Last allowed WAIT cycle without done: respond with an error.
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_data  <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= N_REQ'(1) << r_owner;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                RESP: begin
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
                    r_err       <= 1'b0;
`endif
                    if (r_owner == IW'(N_REQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_owner + IW'(1);
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = r_busy;
    assign o_m_valid   = r_m_valid;
    assign o_m_a       = r_m_a;
    assign o_m_b       = r_m_b;
`ifdef MULT_ARB_TIMEOUT_EN
    assign o_err       = r_err;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter with a latency-8 multiplier model.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 8;
    localparam int TMO = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] a_in = '0;
    logic [N*W-1:0] b_in = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [2*W-1:0] rsp_data;
    logic           err;
    logic           busy;
    logic           m_valid;
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;
    logic [2*W-1:0] m_mult;
    logic           m_done;

    logic           model_en = 1'b1;
    logic           man_done = 1'b0;
    logic [2*W-1:0] man_mult = '0;
    logic           mdl_done = 1'b0;
    logic [2*W-1:0] mdl_mult = '0;
    logic [2*W-1:0] mdl_prod = '0;
    int             mdl_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_a         (a_in),
        .i_b         (b_in),
        .o_gnt       (gnt),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_err       (err),
        .o_busy      (busy),
        .o_m_valid   (m_valid),
        .o_m_a       (m_a),
        .o_m_b       (m_b),
        .i_m_mult    (m_mult),
        .i_m_done    (m_done)
    );

    // Multiplier model: done pulses LAT cycles after the start pulse is sampled.
    always @(posedge clk) begin
        if (model_en && m_valid) begin
            mdl_cnt  <= LAT;
            mdl_prod <= {8'b0, m_a} * {8'b0, m_b};
            mdl_done <= 1'b0;
        end else if (mdl_cnt == 1) begin
            mdl_done <= 1'b1;
            mdl_mult <= mdl_prod;
            mdl_cnt  <= 0;
        end else begin
            mdl_done <= 1'b0;
            if (mdl_cnt > 1) mdl_cnt <= mdl_cnt - 1;
        end
    end

    assign m_done = mdl_done | man_done;
    assign m_mult = man_done ? man_mult : mdl_mult;

    typedef struct {
        int        idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_for(input bit want_rsp, input int limit, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            seen = want_rsp ? (rsp_valid != '0) : (gnt != '0);
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no pulse within %0d cycles", want_rsp ? "rsp_wait" : "gnt_wait",
                     limit);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_a"}, 32'(m_a), 0);
        check({tag, "_m_b"}, 32'(m_b), 0);
    endtask

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        a_in[idx*W +: W] = a;
        b_in[idx*W +: W] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen_rsp;
        logic [N-1:0] onehot;

        vecs[0] = '{idx: 2, a: 8'd4,   b: 8'd4,   prod: 16'd16};
        vecs[1] = '{idx: 2, a: 8'd255, b: 8'd255, prod: 16'd65025};
        vecs[2] = '{idx: 0, a: 8'd12,  b: 8'd11,  prod: 16'd132};
        vecs[3] = '{idx: 1, a: 8'd0,   b: 8'd200, prod: 16'd0};
        vecs[4] = '{idx: 3, a: 8'd128, b: 8'd2,   prod: 16'd256};

        // Reset state
        repeat (2) @(negedge clk);
        check_zero_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 0);

        // Single-request vectors
        for (int v = 0; v < 5; v++) begin
            onehot = N'(1) << vecs[v].idx;
            a_in = '0;
            b_in = '0;
            set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
            req = onehot;
            wait_for(1'b0, 20, cyc);
            check("gnt_latency", 32'(cyc), 1);
            check("gnt", 32'(gnt), 32'(onehot));
            check("m_valid", 32'(m_valid), 1);
            check("m_a", 32'(m_a), 32'(vecs[v].a));
            check("m_b", 32'(m_b), 32'(vecs[v].b));
            check("busy_issue", 32'(busy), 1);
            req = '0;
            @(negedge clk);
            check("gnt_pulse", 32'(gnt), 0);
            check("m_valid_pulse", 32'(m_valid), 0);
            check("m_a_hold", 32'(m_a), 32'(vecs[v].a));
            wait_for(1'b1, 50, cyc);
            check("rsp_latency", 32'(cyc + 1), 32'(LAT + 2));
            check("rsp_valid", 32'(rsp_valid), 32'(onehot));
            check("rsp_data", 32'(rsp_data), 32'(vecs[v].prod));
            check("err", 32'(err), 0);
            @(negedge clk);
            check("rsp_pulse", 32'(rsp_valid), 0);
            check("rsp_data_held", 32'(rsp_data), 32'(vecs[v].prod));
            check("busy_idle", 32'(busy), 0);
        end

        // All four request at once, each drops on its grant
        for (int i = 0; i < N; i++) set_ops(i, 8'(i + 1), 8'd3);
        req = '1;
        for (int e = 0; e < N; e++) begin
            wait_for(1'b0, 20, cyc);
            check("sim_gnt", 32'(gnt), 32'(1 << e));
            req[e] = 1'b0;
            wait_for(1'b1, 50, cyc);
            check("sim_rsp_valid", 32'(rsp_valid), 32'(1 << e));
            check("sim_rsp_data", 32'(rsp_data), 32'(3 * (e + 1)));
        end

        // Two requesters re-asserting immediately must alternate
        set_ops(0, 8'd10, 8'd10);
        set_ops(1, 8'd20, 8'd3);
        req = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            int e;
            e = i % 2;
            wait_for(1'b0, 20, cyc);
            check("fair_gnt", 32'(gnt), 32'(1 << e));
            req[e] = 1'b0;
            wait_for(1'b1, 50, cyc);
            check("fair_rsp_valid", 32'(rsp_valid), 32'(1 << e));
            check("fair_rsp_data", 32'(rsp_data), (e == 0) ? 32'd100 : 32'd60);
            req[e] = 1'b1;
        end
        req = '0;
        repeat (3) @(negedge clk);
        check("fair_idle_busy", 32'(busy), 0);

        // Reset while waiting, then a stale done must be ignored
        model_en = 1'b0;
        set_ops(1, 8'd7, 8'd7);
        req = 4'b0010;
        wait_for(1'b0, 20, cyc);
        check("rstwait_gnt", 32'(gnt), 32'b0010);
        req = '0;
        repeat (3) @(negedge clk);
        check("rstwait_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_zero_outs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        man_mult = 16'd99;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stale_rsp_valid", 32'(rsp_valid), 0);
            check("stale_rsp_data", 32'(rsp_data), 0);
            check("stale_busy", 32'(busy), 0);
        end
        model_en = 1'b1;
        set_ops(0, 8'd9, 8'd9);
        set_ops(3, 8'd5, 8'd6);
        req = 4'b1001;
        wait_for(1'b0, 20, cyc);
        check("ptr_reset_gnt", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        wait_for(1'b1, 50, cyc);
        check("ptr_reset_rsp", 32'(rsp_data), 81);
        wait_for(1'b0, 20, cyc);
        check("req3_gnt", 32'(gnt), 32'b1000);
        req = '0;
        wait_for(1'b1, 50, cyc);
        check("req3_rsp_valid", 32'(rsp_valid), 32'b1000);
        check("req3_rsp_data", 32'(rsp_data), 30);

        // Multiplier that never completes
        model_en = 1'b0;
        set_ops(2, 8'd3, 8'd3);
        repeat (2) @(negedge clk);
        req = 4'b0100;
        wait_for(1'b0, 20, cyc);
        check("tmo_gnt", 32'(gnt), 32'b0100);
        req = '0;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_for(1'b1, TMO + 20, cyc);
        check("tmo_latency", 32'(cyc), 32'(TMO + 1));
        check("tmo_rsp_valid", 32'(rsp_valid), 32'b0100);
        check("tmo_err", 32'(err), 1);
        check("tmo_rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        check("tmo_err_pulse", 32'(err), 0);
        check("tmo_busy", 32'(busy), 0);
`else
        seen_rsp = 0;
        repeat (TMO + 16) begin
            @(negedge clk);
            if (rsp_valid != '0 || err) seen_rsp++;
        end
        check("hang_no_rsp", 32'(seen_rsp), 0);
        check("hang_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1 check("hang_reset_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
